mem_bus_arbiter: RTL

- Shares the single sram-like memory bus between the instruction-fetch requester and the data (load/store) requester.
- Allows one outstanding transaction at a time.
- Translates each virtual address to a physical address with the kseg mapping and flags kseg1 accesses as uncached.
- Sits between the pipeline's IF/MEM request logic and the top-level bus bridge.

---
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like bus between instruction fetch and load/store, one transaction in flight,
// with kseg0/kseg1 address translation. Define MEM_ARB_RR_EN for round-robin arbitration on contention.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_uncached,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned SEG_W = 3;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t state;
    owner_t owner;

    logic              grant_any;
    logic              grant_data;
    logic [ADDR_W-1:0] sel_vaddr;
    logic [ADDR_W-1:0] sel_paddr;
    logic              sel_uncached;

    // kseg0/kseg1 fold onto the low 512 MB; kseg1 is the uncached window
    function automatic logic [ADDR_W:0] translate(input logic [ADDR_W-1:0] vaddr);
        logic [SEG_W-1:0] seg;
        seg = vaddr[ADDR_W-1 -: SEG_W];
        case (seg)
            3'b100:  translate = {1'b0, SEG_W'(0), vaddr[ADDR_W-SEG_W-1:0]};
            3'b101:  translate = {1'b1, SEG_W'(0), vaddr[ADDR_W-SEG_W-1:0]};
            default: translate = {1'b0, vaddr};
        endcase
    endfunction

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    always_comb begin
        grant_any = inst_req | data_req;
        if (inst_req && data_req) grant_data = (last_grant == OWN_INST);
        else                      grant_data = data_req;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         last_grant <= OWN_INST;
        else if (state == IDLE && grant_any) last_grant <= grant_data ? OWN_DATA : OWN_INST;
    end
`else
    always_comb begin
        grant_any  = inst_req | data_req;
        grant_data = data_req;
    end
`endif

    assign sel_vaddr                 = grant_data ? data_addr : inst_addr;
    assign {sel_uncached, sel_paddr} = translate(sel_vaddr);

    // State, owner and registered bus payload
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            owner        <= OWN_INST;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            bus_size     <= 2'd0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_uncached <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner        <= grant_data ? OWN_DATA : OWN_INST;
                        bus_req      <= 1'b1;
                        bus_wr       <= grant_data ? data_wr : 1'b0;
                        bus_size     <= grant_data ? data_size : 2'd2;
                        bus_addr     <= sel_paddr;
                        bus_wdata    <= grant_data ? data_wdata : '0;
                        bus_uncached <= sel_uncached;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) state <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Handshake pulses follow the bus in the same cycle, routed only to the owner
    assign inst_addr_ok = (state == ADDR) && bus_addr_ok && (owner == OWN_INST);
    assign data_addr_ok = (state == ADDR) && bus_addr_ok && (owner == OWN_DATA);
    assign inst_data_ok = (state == WAIT) && bus_data_ok && (owner == OWN_INST);
    assign data_data_ok = (state == WAIT) && bus_data_ok && (owner == OWN_DATA);

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule
